hex_digit_scanner: RTL

//  Consumes the 16-bit out_port of the hex-digits PIO and drives four multiplexed

---
 rtl/hex_disp_pkg.sv | 42 ++++
 rtl/hex_seg_decode.sv | 11 +
 rtl/hex_digit_scanner.sv | 106 ++++++++++
 3 files changed

// File: rtl/hex_disp_pkg.sv
// Shared constants and the hex-to-7-segment table for the multiplexed digit display.
package hex_disp_pkg;

  localparam int unsigned NUM_DIGITS  = 4;
  localparam int unsigned DIGIT_IDX_W = $clog2(NUM_DIGITS);
  localparam int unsigned NIBBLE_W    = 4;
  localparam int unsigned SEG_W       = 7;
  localparam int unsigned VALUE_W     = NUM_DIGITS * NIBBLE_W;

  localparam logic [SEG_W-1:0]      SEG_BLANK  = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] DIGITS_OFF = 4'hF;

  typedef enum logic {
    PH_BLANK = 1'b0,
    PH_DRIVE = 1'b1
  } phase_e;

  // Active-low segment pattern, bit6 = g ... bit0 = a.
  function automatic logic [SEG_W-1:0] hex_to_seg(input logic [NIBBLE_W-1:0] nibble);
    logic [SEG_W-1:0] seg;
    case (nibble)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble to active-low 7-segment decoder.
module hex_seg_decode
  import hex_disp_pkg::*;
(
  input  logic [NIBBLE_W-1:0] nibble,
  output logic [SEG_W-1:0]    seg_n_c
);

  always_comb seg_n_c = hex_to_seg(nibble);

endmodule

// File: rtl/hex_digit_scanner.sv
// Four-digit common-anode scanner: per-slot blank gap, frame-latched shadow value,
// optional leading-zero blanking, all outputs registered.
module hex_digit_scanner
  import hex_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 12500,
  parameter int unsigned BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [VALUE_W-1:0]    hex_value,
  input  logic                  disp_en,
  input  logic                  lzb_en,
  output logic [SEG_W-1:0]      seg_n,
  output logic [NUM_DIGITS-1:0] digit_n,
  output logic                  frame_done
);

  localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [CNT_W-1:0]       slot_cnt,  slot_cnt_nxt;
  logic [DIGIT_IDX_W-1:0] digit_idx, digit_idx_nxt;
  logic [VALUE_W-1:0]     shadow,    shadow_nxt;
  logic [SEG_W-1:0]       seg_n_nxt;
  logic [NUM_DIGITS-1:0]  digit_n_nxt;
  logic                   frame_done_nxt;

  logic                   slot_wrap_c;
  logic                   frame_wrap_c;
  logic                   lead_zero_c;
  logic                   lit_c;
  phase_e                 phase_c;
  logic [NIBBLE_W-1:0]    nibble_c;
  logic [SEG_W-1:0]       dec_seg_c;

  hex_seg_decode u_dec (
    .nibble  (nibble_c),
    .seg_n_c (dec_seg_c)
  );

  // A digit is a leading zero when it and every more-significant nibble are zero.
  always_comb begin
    lead_zero_c = 1'b0;
    case (digit_idx)
      2'd3:    lead_zero_c = (shadow[15:12] == 4'h0);
      2'd2:    lead_zero_c = (shadow[15:8]  == 8'h00);
      2'd1:    lead_zero_c = (shadow[15:4]  == 12'h000);
      default: lead_zero_c = 1'b0;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    slot_cnt_nxt   = slot_cnt;
    digit_idx_nxt  = digit_idx;
    shadow_nxt     = shadow;
    seg_n_nxt      = SEG_BLANK;
    digit_n_nxt    = DIGITS_OFF;
    frame_done_nxt = 1'b0;

    slot_wrap_c  = (slot_cnt == CNT_W'(SCAN_DIV - 1));
    frame_wrap_c = slot_wrap_c && (digit_idx == DIGIT_IDX_W'(NUM_DIGITS - 1));
    nibble_c     = shadow[{digit_idx, 2'b00} +: NIBBLE_W];

    if (slot_wrap_c) begin
      slot_cnt_nxt  = '0;
      digit_idx_nxt = digit_idx + DIGIT_IDX_W'(1);
    end else begin
      slot_cnt_nxt  = slot_cnt + CNT_W'(1);
    end

    if (frame_wrap_c) begin
      shadow_nxt     = hex_value;
      frame_done_nxt = 1'b1;
    end

    // The wrap edge loads blank so the old digit never bleeds into the next slot.
    phase_c = ((slot_cnt >= CNT_W'(BLANK_CYCLES)) && !slot_wrap_c) ? PH_DRIVE : PH_BLANK;
    lit_c   = (phase_c == PH_DRIVE) && disp_en && !(lzb_en && lead_zero_c);

    if (lit_c) begin
      seg_n_nxt   = dec_seg_c;
      digit_n_nxt = ~(NUM_DIGITS'(1) << digit_idx);
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_cnt   <= '0;
      digit_idx  <= '0;
      shadow     <= '0;
      seg_n      <= SEG_BLANK;
      digit_n    <= DIGITS_OFF;
      frame_done <= 1'b0;
    end else begin
      slot_cnt   <= slot_cnt_nxt;
      digit_idx  <= digit_idx_nxt;
      shadow     <= shadow_nxt;
      seg_n      <= seg_n_nxt;
      digit_n    <= digit_n_nxt;
      frame_done <= frame_done_nxt;
    end
  end

endmodule
